// File: rtl/pwm_capture_pkg.sv
// -----------------------------------------------------------------------------
// pwm_capture_pkg
// Shared definitions for the PWM capture block: default counter width,
// default stall timeout and the capture FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package pwm_capture_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam logic [31:0] TIMEOUT_DEF = 32'h00FF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// -----------------------------------------------------------------------------
// pwm_capture_if
// Bundles the capture control input, the raw PWM pin and the read-only
// result/status registers.
//   en            capture enable (0 = synchronous clear)
//   pwm_in        asynchronous PWM pin
//   period_o      cycles between the last two rising edges, minus 1
//   pulse_width_o high cycles within that period
//   valid_o       1-clk pulse when results update
//   timeout_o     sticky stall flag
//   level_o       synchronised pin level
// master: the capture block. slave: the register file / stimulus side.
// -----------------------------------------------------------------------------
interface pwm_capture_if
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] pulse_width_o;
    logic             valid_o;
    logic             timeout_o;
    logic             level_o;

    modport master (
        input  en, pwm_in,
        output period_o, pulse_width_o, valid_o, timeout_o, level_o
    );

    modport slave (
        output en, pwm_in,
        input  period_o, pulse_width_o, valid_o, timeout_o, level_o
    );
endinterface

// File: rtl/pwm_capture_in_sync.sv
// -----------------------------------------------------------------------------
// pwm_capture_in_sync
// Two-flop synchroniser for the PWM pin followed by a delay flop for edge
// detection.
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   i_async  in   asynchronous pin
//   o_level  out  synchronised level (s2)
//   o_rise   out  s2 & ~s3
//   o_fall   out  ~s2 & s3 (reserved)
// The chain is cleared only by rst, not by the capture enable, so toggling
// the enable never fabricates an edge from a pin that was already high.
// -----------------------------------------------------------------------------
module pwm_capture_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchroniser chain plus edge-detect delay stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;
endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures period and high time of an external PWM signal in clk cycles,
// reported with generator register semantics (period = cycles - 1,
// pulse width = high cycles).
//   clk   in   system clock
//   rst   in   synchronous reset, active-high (priority over en)
//   bus   pwm_capture_if.master: en / pwm_in in, results and status out
// A stall (no rising edge for TIMEOUT cycles) sets a sticky timeout flag;
// level_o then tells stuck-high from stuck-low.
// -----------------------------------------------------------------------------
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned      CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
    input  logic           clk,
    input  logic           rst,
    pwm_capture_if.master  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_pulse_width;
    logic             r_valid;
    logic             r_timeout;
    logic             r_level;

    logic w_s2;
    logic w_rise;
    logic w_fall_unused;

    logic w_restart;
    logic w_capture;
    logic w_timeout_hit;
    logic w_count_cnt;
    logic w_count_hi;

    pwm_capture_in_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.pwm_in),
        .o_level (w_s2),
        .o_rise  (w_rise),
        .o_fall  (w_fall_unused)
    );

    // FSM state register; deasserting en returns to IDLE in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (!bus.en) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_ARM;
            end
            ST_ARM: begin
                if (w_rise) begin
                    w_next_state = ST_MEASURE;
                end else begin
                    w_next_state = ST_ARM;
                end
            end
            ST_MEASURE: begin
                // A rise in the timeout cycle wins: keep measuring
                if (w_rise) begin
                    w_next_state = ST_MEASURE;
                end else if (r_cnt == TIMEOUT) begin
                    w_next_state = ST_ARM;
                end else begin
                    w_next_state = ST_MEASURE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM output decode driving the datapath
    always_comb begin
        w_restart     = 1'b0;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        w_count_cnt   = 1'b0;
        w_count_hi    = 1'b0;
        case (r_state)
            ST_ARM: begin
                // cnt also runs while armed so a pin that never toggles
                // after enable is still flagged as stalled
                if (w_rise) begin
                    w_restart = 1'b1;
                end else begin
                    w_count_cnt   = 1'b1;
                    w_timeout_hit = (r_cnt == TIMEOUT);
                end
            end
            ST_MEASURE: begin
                if (w_rise) begin
                    w_restart = 1'b1;
                    w_capture = 1'b1;
                end else begin
                    w_count_cnt   = 1'b1;
                    w_count_hi    = 1'b1;
                    w_timeout_hit = (r_cnt == TIMEOUT);
                end
            end
            default: begin
                w_restart = 1'b0;
            end
        endcase
    end

    // Counters, result and status registers
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            r_cnt         <= '0;
            r_hi          <= '0;
            r_period      <= '0;
            r_pulse_width <= '0;
            r_valid       <= 1'b0;
            r_timeout     <= 1'b0;
            r_level       <= 1'b0;
        end else begin
            r_level <= w_s2;
            r_valid <= w_capture;

            if (w_capture) begin
                r_period      <= r_cnt;
                r_pulse_width <= r_hi;
                r_timeout     <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end

            // The rise cycle itself is the first high cycle of the new period
            if (w_restart) begin
                r_cnt <= '0;
                r_hi  <= CNT_ONE;
            end else begin
                if (w_count_cnt && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
                if (w_count_hi && w_s2 && (r_hi != CNT_MAX)) begin
                    r_hi <= r_hi + CNT_ONE;
                end
            end
        end
    end

    assign bus.period_o      = r_period;
    assign bus.pulse_width_o = r_pulse_width;
    assign bus.valid_o       = r_valid;
    assign bus.timeout_o     = r_timeout;
    assign bus.level_o       = r_level;
endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
// Directed bench for pwm_capture. A behavioural PWM generator drives the pin
// (period = cycles-1, pulse width = high cycles); expected results are the
// generator settings themselves. TIMEOUT is shortened to 200 cycles.
// -----------------------------------------------------------------------------
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_capture_if #(.CNT_W(32)) bus ();

    pwm_capture #(
        .CNT_W   (32),
        .TIMEOUT (32'd200)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Generator state: settings written by the stimulus, counter by the generator
    int gen_period = 9;
    int gen_pw     = 0;
    int gen_cnt    = 0;
    int gen_req    = 0;
    int gen_ack    = 0;

    // PWM generator, updates the pin away from the capture edge
    always @(negedge clk) begin
        if (gen_req != gen_ack) begin
            gen_ack = gen_req;
            gen_cnt = 0;
        end else if (gen_cnt >= gen_period) begin
            gen_cnt = 0;
        end else begin
            gen_cnt = gen_cnt + 1;
        end
        bus.pwm_in = (gen_cnt < gen_pw);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_gen(input int p, input int w, input bit restart);
        gen_period = p;
        gen_pw     = w;
        if (restart) gen_req = gen_req + 1;
    endtask

    task automatic wait_valid(input string tag, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.valid_o && cyc < budget);
        check_eq({tag, "_valid_seen"}, 32'(bus.valid_o), 32'd1);
    endtask

    task automatic wait_timeout(input int budget, output int cyc, output bit saw_valid);
        cyc       = 0;
        saw_valid = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.valid_o) saw_valid = 1'b1;
        end while (!bus.timeout_o && cyc < budget);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_period"}, bus.period_o, 32'd0);
        check_eq({tag, "_pw"}, bus.pulse_width_o, 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
        check_eq({tag, "_timeout"}, 32'(bus.timeout_o), 32'd0);
        check_eq({tag, "_level"}, 32'(bus.level_o), 32'd0);
    endtask

    // Hard stop if something hangs
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  saw_valid;

        // Reset state
        rst    = 1'b1;
        bus.en = 1'b0;
        set_gen(9, 3, 1'b1);
        tick(5);
        check_zero("reset");

        // Steady 9/3: valid every 10 clk after the second rise
        rst = 1'b0;
        tick(3);
        bus.en = 1'b1;
        wait_valid("s1_first", 60, cyc);
        check_eq("s1_first_period", bus.period_o, 32'd9);
        check_eq("s1_first_pw", bus.pulse_width_o, 32'd3);
        tick(1);
        check_eq("s1_valid_pulse", 32'(bus.valid_o), 32'd0);
        check_eq("s1_hold_period", bus.period_o, 32'd9);
        for (int k = 0; k < 3; k++) begin
            wait_valid("s1_steady", 30, cyc);
            check_eq("s1_interval", (k == 0) ? cyc + 1 : cyc, 32'd10);
            check_eq("s1_period", bus.period_o, 32'd9);
            check_eq("s1_pw", bus.pulse_width_o, 32'd3);
        end

        // Switch to 19/7 mid-run: skip transitional samples, then steady
        set_gen(19, 7, 1'b0);
        wait_valid("s4_skip_a", 60, cyc);
        wait_valid("s4_skip_b", 60, cyc);
        for (int k = 0; k < 2; k++) begin
            wait_valid("s4_steady", 40, cyc);
            check_eq("s4_interval", cyc, 32'd20);
            check_eq("s4_period", bus.period_o, 32'd19);
            check_eq("s4_pw", bus.pulse_width_o, 32'd7);
        end

        // en dropped for one clk mid-period
        tick(5);
        bus.en = 1'b0;
        tick(1);
        check_eq("s5_clr_period", bus.period_o, 32'd0);
        check_eq("s5_clr_pw", bus.pulse_width_o, 32'd0);
        check_eq("s5_clr_valid", 32'(bus.valid_o), 32'd0);
        bus.en = 1'b1;
        wait_valid("s5_rearm", 80, cyc);
        check_eq("s5_two_rises", 32'((cyc >= 20) && (cyc <= 45)), 32'd1);
        check_eq("s5_period", bus.period_o, 32'd19);
        check_eq("s5_pw", bus.pulse_width_o, 32'd7);

        // Stuck low: timeout with level 0, no valid
        rst    = 1'b1;
        bus.en = 1'b0;
        set_gen(99, 0, 1'b1);
        tick(5);
        rst    = 1'b0;
        bus.en = 1'b1;
        wait_timeout(400, cyc, saw_valid);
        check_eq("s2_timeout", 32'(bus.timeout_o), 32'd1);
        check_eq("s2_level", 32'(bus.level_o), 32'd0);
        check_eq("s2_latency", 32'((cyc >= 195) && (cyc <= 210)), 32'd1);
        check_eq("s2_no_valid", 32'(saw_valid), 32'd0);
        check_eq("s2_period", bus.period_o, 32'd0);

        // Stuck high: timeout with level 1
        bus.en = 1'b0;
        set_gen(4, 5, 1'b1);
        tick(5);
        check_eq("s3_en_clears_timeout", 32'(bus.timeout_o), 32'd0);
        bus.en = 1'b1;
        wait_timeout(400, cyc, saw_valid);
        check_eq("s3_timeout", 32'(bus.timeout_o), 32'd1);
        check_eq("s3_level", 32'(bus.level_o), 32'd1);
        check_eq("s3_latency", 32'((cyc >= 195) && (cyc <= 210)), 32'd1);
        check_eq("s3_no_valid", 32'(saw_valid), 32'd0);

        // Resume toggling at 4/2: timeout clears together with valid
        set_gen(4, 2, 1'b1);
        tick(3);
        check_eq("s3_sticky", 32'(bus.timeout_o), 32'd1);
        wait_valid("s3_resume", 40, cyc);
        check_eq("s3_timeout_clr", 32'(bus.timeout_o), 32'd0);
        check_eq("s3_period", bus.period_o, 32'd4);
        check_eq("s3_pw", bus.pulse_width_o, 32'd2);

        // rst while valid_o is high
        wait_valid("s6_pre", 20, cyc);
        rst = 1'b1;
        tick(1);
        check_zero("s6_rst");
        check_eq("s6_state", 32'(dut.r_state), 32'(ST_IDLE));
        rst = 1'b0;
        set_gen(9, 3, 1'b0);
        wait_valid("s6_skip_a", 60, cyc);
        wait_valid("s6_skip_b", 60, cyc);
        for (int k = 0; k < 2; k++) begin
            wait_valid("s6_steady", 30, cyc);
            check_eq("s6_interval", cyc, 32'd10);
            check_eq("s6_period", bus.period_o, 32'd9);
            check_eq("s6_pw", bus.pulse_width_o, 32'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
